// File: rtl/mixcolumn_8_ctrl_if.sv
// Byte-stream handshake bundle for the MixColumns sequencer: an input
// valid/ready byte stream (with per-block bypass flag) and an output
// valid/ready byte stream (with end-of-block marker).
interface mixcolumn_8_ctrl_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_bypass;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;

    // Environment side: produces the input stream, consumes the output stream.
    modport master (
        output s_data, s_valid, s_bypass, m_ready,
        input  s_ready, m_data, m_valid, m_last
    );

    // Controller side: consumes the input stream, produces the output stream.
    modport slave (
        input  s_data, s_valid, s_bypass, m_ready,
        output s_ready, m_data, m_valid, m_last
    );
endinterface

// File: rtl/mixcolumn_8_ctrl.sv
// Sequencer for the byte-serial MixColumns datapath. Collects a 4-byte
// column, feeds it to the datapath over four back-to-back cycles with the
// clear/accumulate mask, captures and reorders the result, and streams it
// out. A per-block bypass flag passes columns through untouched.
module mixcolumn_8_ctrl #(
    parameter int NCOL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mixcolumn_8_ctrl_if.slave bus,
    output logic [7:0]        dp_din,
    output logic [7:0]        dp_en,
    input  logic [7:0]        dp_dout0,
    input  logic [7:0]        dp_dout1,
    input  logic [7:0]        dp_dout2,
    input  logic [7:0]        dp_dout3,
    output logic              busy
);

    localparam int            CW       = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(NCOL - 1);

    typedef enum logic [1:0] {
        COLLECT,
        WAIT,
        FEED,
        CAP
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    icnt_q, icnt_d;
    logic [1:0]    k_q, k_d;
    logic [1:0]    ocnt_q, ocnt_d;
    logic [2:0]    obuf_cnt_q, obuf_cnt_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] col_out_q, col_out_d;
    logic          bypass_q, bypass_d;
    logic [7:0]    ibuf_q [4];
    logic [7:0]    ibuf_d [4];
    logic [7:0]    obuf_q [4];
    logic [7:0]    obuf_d [4];

    logic          m_valid_c;
    logic          s_fire;
    logic          m_fire;

    // Output stream and status are pure functions of registered state, so
    // m_data cannot move while a stalled byte is being offered.
    assign m_valid_c   = (obuf_cnt_q != 3'd0);
    assign bus.m_valid = m_valid_c;
    assign bus.m_data  = obuf_q[ocnt_q];
    assign bus.m_last  = m_valid_c && (ocnt_q == 2'd3) && (col_out_q == COL_LAST);
    assign bus.s_ready = (state_q == COLLECT);
    assign busy        = (state_q != COLLECT) || m_valid_c;

    assign s_fire = bus.s_valid && (state_q == COLLECT);
    assign m_fire = m_valid_c && bus.m_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, bypass flag and column buffers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icnt_q     <= 2'd0;
            k_q        <= 2'd0;
            ocnt_q     <= 2'd0;
            obuf_cnt_q <= 3'd0;
            col_q      <= '0;
            col_out_q  <= '0;
            bypass_q   <= 1'b0;
            // NOTE: the buffers are only 4 bytes each and obuf drives m_data
            // directly, so they are reset to give a defined output after reset.
            for (int i = 0; i < 4; i++) begin
                ibuf_q[i] <= 8'h00;
                obuf_q[i] <= 8'h00;
            end
        end else begin
            icnt_q     <= icnt_d;
            k_q        <= k_d;
            ocnt_q     <= ocnt_d;
            obuf_cnt_q <= obuf_cnt_d;
            col_q      <= col_d;
            col_out_q  <= col_out_d;
            bypass_q   <= bypass_d;
            ibuf_q     <= ibuf_d;
            obuf_q     <= obuf_d;
        end
    end

    // Next-state logic, buffer updates and datapath drive.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_d    = state_q;
        icnt_d     = icnt_q;
        k_d        = k_q;
        ocnt_d     = ocnt_q;
        obuf_cnt_d = obuf_cnt_q;
        col_d      = col_q;
        col_out_d  = col_out_q;
        bypass_d   = bypass_q;
        ibuf_d     = ibuf_q;
        obuf_d     = obuf_q;
        dp_din     = 8'h00;
        dp_en      = 8'h00;

        // Output drain runs in every state; it is the only overlap allowed.
        if (m_fire) begin
            // NOTE: blocking assignments here only compute the _d values
            // combinationally; the registers update with <= in always_ff.
            ocnt_d     = ocnt_q + 2'd1;
            obuf_cnt_d = obuf_cnt_q - 3'd1;
        end

        unique case (state_q)
            COLLECT: begin
                if (s_fire) begin
                    ibuf_d[icnt_q] = bus.s_data;
                    icnt_d         = icnt_q + 2'd1;
                    // Bypass is a per-block property taken from its first byte.
                    if ((col_q == '0) && (icnt_q == 2'd0)) begin
                        bypass_d = bus.s_bypass;
                    end
                    if (icnt_q == 2'd3) begin
                        k_d = 2'd0;
                        if (obuf_cnt_q != 3'd0) begin
                            state_d = WAIT;
                        end else if (bypass_q) begin
                            state_d = CAP;
                        end else begin
                            state_d = FEED;
                        end
                    end
                end
            end

            // Hold the new column until the previous one has fully drained;
            // the decision uses the registered count, not this cycle's drain.
            WAIT: begin
                if (obuf_cnt_q == 3'd0) begin
                    k_d     = 2'd0;
                    state_d = bypass_q ? CAP : FEED;
                end
            end

            // Four uninterrupted cycles: clear on a0, accumulate a1..a3.
            FEED: begin
                dp_din = ibuf_q[k_q];
                dp_en  = (k_q == 2'd0) ? 8'h00 : 8'hFF;
                k_d    = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d = CAP;
                end
            end

            // Datapath registers are sampled before they change; their
            // rotation leaves b0 in dout3 and b1..b3 in dout0..dout2.
            CAP: begin
                if (bypass_q) begin
                    obuf_d = ibuf_q;
                end else begin
                    obuf_d = '{dp_dout3, dp_dout0, dp_dout1, dp_dout2};
                end
                obuf_cnt_d = 3'd4;
                ocnt_d     = 2'd0;
                icnt_d     = 2'd0;
                col_out_d  = col_q;
                col_d      = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
                state_d    = COLLECT;
            end

            default: begin
                state_d = COLLECT;
            end
        endcase
    end

endmodule

// File: tb/tb_mixcolumn_8_ctrl.sv
// Self-checking bench for mixcolumn_8_ctrl. Includes a behavioural model of
// the byte-serial MixColumns datapath (rotating accumulators) and a golden
// MixColumns function; directed table vectors plus multi-cycle sequences.
module tb_mixcolumn_8_ctrl;

    localparam int TMO = 500;

    typedef struct {
        logic [31:0] a;   // {a0,a1,a2,a3}
        logic [31:0] b;   // {b0,b1,b2,b3}
    } vec_t;

    typedef struct {
        logic [7:0]  d;
        logic        last;
        int unsigned cyc;
    } rx_t;

    typedef struct {
        logic [7:0] d;
        logic       last;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  dp_din;
    logic [7:0]  dp_en;
    logic [7:0]  dp_dout0, dp_dout1, dp_dout2, dp_dout3;
    logic        busy;
    logic [7:0]  dp_r [4];

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          rdy_mode = 1;   // 0 hold, 1 always, 2 random, 3 budget
    int          budget = 0;
    rx_t         rxq [$];
    exp_t        expq [$];
    vec_t        vec [4];

    mixcolumn_8_ctrl_if bus ();

    mixcolumn_8_ctrl #(.NCOL(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dp_din   (dp_din),
        .dp_en    (dp_en),
        .dp_dout0 (dp_dout0),
        .dp_dout1 (dp_dout1),
        .dp_dout2 (dp_dout2),
        .dp_dout3 (dp_dout3),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input int c, input logic [7:0] x);
        case (c)
            2:       return xt(x);
            3:       return xt(x) ^ x;
            default: return x;
        endcase
    endfunction

    function automatic int coef(input int j);
        case (j)
            1:       return 3;
            2:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] mixcol(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        a0 = a[31:24]; a1 = a[23:16]; a2 = a[15:8]; a3 = a[7:0];
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    // Datapath model: each register takes its neighbour (or zero when the
    // mask clears) XOR coef*din, so results rotate out as b1,b2,b3,b0.
    always @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            dp_r[j] <= (dp_en[2*j] ? dp_r[(j + 1) % 4] : 8'h00) ^ gm(coef(j), dp_din);
        end
    end
    assign dp_dout0 = dp_r[0];
    assign dp_dout1 = dp_r[1];
    assign dp_dout2 = dp_r[2];
    assign dp_dout3 = dp_r[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Output consumer: drives m_ready, records accepted bytes, and checks
    // that a stalled byte stays valid and stable.
    initial begin
        logic       stall_prev;
        logic [7:0] data_prev;
        stall_prev  = 1'b0;
        data_prev   = 8'h00;
        bus.m_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && stall_prev) begin
                check("stall m_valid", 32'(bus.m_valid), 32'd1);
                check("stall m_data", 32'(bus.m_data), 32'(data_prev));
            end
            case (rdy_mode)
                0:       bus.m_ready = 1'b0;
                1:       bus.m_ready = 1'b1;
                2:       bus.m_ready = 1'($urandom_range(0, 1));
                default: bus.m_ready = (budget > 0);
            endcase
            if (rst_n && bus.m_valid && bus.m_ready) begin
                rxq.push_back('{d: bus.m_data, last: bus.m_last, cyc: cyc});
                if (rdy_mode == 3) budget--;
            end
            stall_prev = rst_n && bus.m_valid && !bus.m_ready;
            data_prev  = bus.m_data;
        end
    end

    // FEED monitor: every accumulate run must be exactly three cycles long.
    initial begin
        int run;
        run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run = 0;
            end else if (dp_en == 8'hFF) begin
                run++;
            end else begin
                if (run != 0) check("feed run length", 32'(run), 32'd3);
                run = 0;
            end
        end
    end

    // Offer one column; acc is the cycle in which the 4th byte is accepted.
    task automatic send_col(input logic [31:0] a, input logic [3:0] byp,
                            input bit gaps, output int unsigned acc);
        int n;
        acc = 0;
        for (int b = 0; b < 4; b++) begin
            if (gaps) begin
                bus.s_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            bus.s_data   = a[31 - 8*b -: 8];
            bus.s_bypass = byp[b];
            bus.s_valid  = 1'b1;
            n = 0;
            while (!bus.s_ready && n < TMO) begin
                @(negedge clk);
                n++;
            end
            if (n >= TMO) timeout("s_ready wait");
            if (b == 3) acc = cyc;
            @(negedge clk);
        end
        bus.s_valid  = 1'b0;
        bus.s_bypass = 1'b0;
        bus.s_data   = 8'h00;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || bus.m_valid) && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) timeout("idle wait");
    endtask

    task automatic wait_rx(input int cnt, input int limit);
        int n;
        n = 0;
        while (rxq.size() < cnt && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) timeout("rx count wait");
    endtask

    task automatic wait_mvalid();
        int n;
        n = 0;
        while (!bus.m_valid && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) timeout("m_valid wait");
    endtask

    // Called in the cycle after the 4th accept: FEED k=0..3 then CAP.
    task automatic feed_check(input string tag, input logic [31:0] a);
        for (int k = 0; k < 4; k++) begin
            check({tag, " dp_en"}, 32'(dp_en), (k == 0) ? 32'h00 : 32'hFF);
            check({tag, " dp_din"}, 32'(dp_din), 32'(a[31 - 8*k -: 8]));
            @(negedge clk);
        end
        check({tag, " cap dp_en"}, 32'(dp_en), 32'h00);
        check({tag, " cap dp_din"}, 32'(dp_din), 32'h00);
    endtask

    // Pop four received bytes and compare data, m_last and b0 latency.
    task automatic check_col(input string tag, input logic [31:0] exp, input logic last_exp,
                             input int unsigned base, input int lat);
        check({tag, " byte count"}, 32'(rxq.size() >= 4), 32'd1);
        if (rxq.size() >= 4) begin
            if (lat >= 0) check({tag, " b0 latency"}, 32'(rxq[0].cyc - base), 32'(lat));
            for (int j = 0; j < 4; j++) begin
                check({tag, " data"}, 32'(rxq[0].d), 32'(exp[31 - 8*j -: 8]));
                check({tag, " m_last"}, 32'(rxq[0].last), 32'(last_exp && (j == 3)));
                void'(rxq.pop_front());
            end
        end
    endtask

    initial begin
        int unsigned acc;
        int unsigned d;
        logic [31:0] a;
        logic [31:0] e;
        logic [3:0]  byp;
        logic        blk_byp;

        vec[0] = '{a: 32'hdb135345, b: 32'h8e4da1bc};
        vec[1] = '{a: 32'hf20a225c, b: 32'h9fdc589d};
        vec[2] = '{a: 32'hd4bf5d30, b: 32'h046681e5};
        vec[3] = '{a: 32'he0b452ae, b: 32'he0cb199a};

        bus.s_data   = 8'h00;
        bus.s_valid  = 1'b0;
        bus.s_bypass = 1'b0;
        rst_n        = 1'b0;
        rdy_mode     = 1;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst s_ready", 32'(bus.s_ready), 32'd1);
        check("rst m_valid", 32'(bus.m_valid), 32'd0);
        check("rst m_last", 32'(bus.m_last), 32'd0);
        check("rst m_data", 32'(bus.m_data), 32'h00);
        check("rst dp_din", 32'(dp_din), 32'h00);
        check("rst dp_en", 32'(dp_en), 32'h00);
        check("rst busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Block of four MixColumns columns, one at a time from idle.
        for (int i = 0; i < 4; i++) begin
            send_col(vec[i].a, 4'b0000, 1'b0, acc);
            feed_check($sformatf("mix c%0d", i), vec[i].a);
            wait_idle();
            check_col($sformatf("mix c%0d", i), vec[i].b, i == 3, acc, 6);
        end

        // Bypass block: flag set on byte 0 only, toggling noise elsewhere.
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       byp = 4'b1011;
                1:       byp = 4'b1010;
                2:       byp = 4'b0101;
                default: byp = 4'b1100;
            endcase
            send_col(vec[i].a, byp, 1'b0, acc);
            wait_idle();
            check_col($sformatf("byp c%0d", i), vec[i].a, i == 3, acc, 2);
        end

        // Backpressure: column 0 held in obuf while column 1 is collected.
        rdy_mode = 0;
        send_col(vec[0].a, 4'b0000, 1'b0, acc);
        wait_mvalid();
        check("bp first m_data", 32'(bus.m_data), 32'h8e);
        send_col(vec[1].a, 4'b0000, 1'b0, acc);
        repeat (3) @(negedge clk);
        check("wait s_ready", 32'(bus.s_ready), 32'd0);
        check("wait m_valid", 32'(bus.m_valid), 32'd1);
        check("wait m_data", 32'(bus.m_data), 32'h8e);
        check("wait busy", 32'(busy), 32'd1);
        check("wait dp_en", 32'(dp_en), 32'h00);
        rdy_mode = 1;
        wait_rx(4, TMO);
        d = (rxq.size() >= 4) ? rxq[3].cyc : cyc;
        check_col("bp c0", vec[0].b, 1'b0, 0, -1);
        wait_idle();
        // obuf empty at d+1 (WAIT sees it), FEED d+2..d+5, CAP d+6, b0 at d+7.
        check_col("bp c1", vec[1].b, 1'b0, d, 7);
        for (int i = 2; i < 4; i++) begin
            send_col(vec[i].a, 4'b0000, 1'b0, acc);
            wait_idle();
            check_col($sformatf("bp c%0d", i), vec[i].b, i == 3, acc, 6);
        end

        // Random gaps and backpressure over 8 blocks, alternating bypass.
        rdy_mode = 2;
        for (int blk = 0; blk < 8; blk++) begin
            blk_byp = 1'(blk % 2);
            for (int c = 0; c < 4; c++) begin
                a   = $urandom;
                e   = blk_byp ? a : mixcol(a);
                byp = 4'($urandom_range(0, 15));
                if (c == 0) byp[0] = blk_byp;
                for (int j = 0; j < 4; j++) begin
                    expq.push_back('{d: e[31 - 8*j -: 8], last: (c == 3) && (j == 3)});
                end
                send_col(a, byp, 1'b1, acc);
            end
        end
        wait_rx(128, 5000);
        rdy_mode = 1;
        wait_idle();
        check("rand byte count", 32'(rxq.size()), 32'd128);
        for (int i = 0; i < 128; i++) begin
            if (rxq.size() == 0 || expq.size() == 0) break;
            check($sformatf("rand data %0d", i), 32'(rxq[0].d), 32'(expq[0].d));
            check($sformatf("rand m_last %0d", i), 32'(rxq[0].last), 32'(expq[0].last));
            void'(rxq.pop_front());
            void'(expq.pop_front());
        end
        rxq.delete();
        expq.delete();

        // Reset during FEED k=2.
        send_col(vec[0].a, 4'b0000, 1'b0, acc);
        while (cyc < acc + 3) @(negedge clk);
        check("feed k2 dp_en", 32'(dp_en), 32'hFF);
        check("feed k2 dp_din", 32'(dp_din), 32'h53);
        rst_n = 1'b0;
        #1;
        check("rst feed s_ready", 32'(bus.s_ready), 32'd1);
        check("rst feed m_valid", 32'(bus.m_valid), 32'd0);
        check("rst feed busy", 32'(busy), 32'd0);
        check("rst feed dp_en", 32'(dp_en), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rxq.delete();

        // Reset with two bytes left in obuf.
        budget   = 0;
        rdy_mode = 3;
        send_col(vec[1].a, 4'b0000, 1'b0, acc);
        wait_mvalid();
        budget = 2;
        wait_rx(2, TMO);
        repeat (2) @(negedge clk);
        check("obuf2 m_valid", 32'(bus.m_valid), 32'd1);
        check("obuf2 m_data", 32'(bus.m_data), 32'h58);
        rst_n = 1'b0;
        #1;
        check("rst obuf s_ready", 32'(bus.s_ready), 32'd1);
        check("rst obuf m_valid", 32'(bus.m_valid), 32'd0);
        check("rst obuf m_last", 32'(bus.m_last), 32'd0);
        check("rst obuf busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        rdy_mode = 1;
        @(negedge clk);
        rxq.delete();

        // Fresh block after reset: column count restarts at 0.
        for (int i = 0; i < 4; i++) begin
            send_col(vec[i].a, 4'b0000, 1'b0, acc);
            wait_idle();
            check_col($sformatf("post c%0d", i), vec[i].b, i == 3, acc, 6);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
